picoblaze_io_bank: RTL
======================

PICOBLAZE_IO_BANK -- requirements
Module: picoblaze_io_bank

Interface
REQ-001 SHALL have parameter CLK_FREQ_HZ, default 250000, giving the reset value of the timer reload (CLK_FREQ_HZ-1); CLK_FREQ_HZ-1 must fit in 24 bits.
REQ-002 SHALL have parameter NUM_OUT, default 4, range 1..8: number of 8-bit output registers.
REQ-003 SHALL have parameter NUM_IN, default 2, range 1..8: number of 8-bit input ports.
REQ-004 SHALL have parameter OUT_BASE, default 8'h10, the port_id of output register 0; register i is at OUT_BASE+i.
REQ-005 SHALL have parameter IN_BASE, default 8'h00, the port_id of input port 0; port i is at IN_BASE+i.
REQ-006 SHALL have parameter TMR_BASE, default 8'hF0; the timer registers occupy TMR_BASE+0..3.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 reset_n  input  1  reset, synchronous and active-low.
REQ-009 port_id  input  8  processor port address.
REQ-010 write_strobe  input  1  one-cycle write qualifier.
REQ-011 out_port  input  8  processor write data.
REQ-012 read_strobe  input  1  read qualifier; decode does not depend on it.
REQ-013 in_port  output  8  registered read data to the processor.
REQ-014 interrupt  output  1  level interrupt request.
REQ-015 interrupt_ack  input  1  one-cycle acknowledge from the processor.
REQ-016 in_data  input  NUM_IN*8  asynchronous input ports; port i is at [8i+7:8i].
REQ-017 out_data  output  NUM_OUT*8  output registers; register i is at [8i+7:8i].

Function
REQ-018 Full address decode SHALL be used: only an exact port_id match qualifies, and a write to an unmapped port_id SHALL change no state.
REQ-019 Write to OUT_BASE+i with write_strobe high SHALL load out_port into register i, visible on out_data the next cycle.
REQ-020 Each in_data bit SHALL pass through a two-flop synchronizer before the read mux.
REQ-021 in_port SHALL be registered every cycle from the current port_id, giving one cycle of latency; unmapped addresses SHALL return 8'h00.
REQ-022 Timer map: TMR_BASE+0/1/2 is the staged reload [7:0]/[15:8]/[23:16] (read/write); TMR_BASE+3 is CTRL on write and STATUS on read.
REQ-023 CTRL bits: bit0 enable (stored); bit1 commit (strobe) copies the staged reload to the active reload and loads the counter with it; bit2 clears overrun (strobe).
REQ-024 STATUS read SHALL return {5'b0, overrun, interrupt, enable}.
REQ-025 With enable=1, the 24-bit counter SHALL decrement each cycle; on reaching 0 it SHALL assert tick for one cycle and reload from the active reload. The tick period is therefore reload+1 cycles.
REQ-026 With enable=0, the counter SHALL hold its value and no tick SHALL be generated; setting enable back to 1 resumes from the held value.
REQ-027 tick SHALL set interrupt on the next edge; interrupt_ack SHALL clear it synchronously. If tick and ack occur in the same cycle, interrupt SHALL stay 1.
REQ-028 A tick while interrupt is already 1 and ack is 0 SHALL set the sticky overrun flag; only CTRL bit2 or reset clears it. If a CTRL bit2 write and a new overrun occur in the same cycle, overrun SHALL stay 1.
REQ-029 A commit in the same cycle as the counter reaching 0 SHALL take priority: the counter loads the newly committed reload and no tick is generated.
REQ-030 Staged reload writes alone SHALL NOT affect the running counter.

Reset
REQ-031 While reset_n=0 at a clk edge: out_data=0, in_port=0, interrupt=0, overrun=0, enable=1, staged and active reload=CLK_FREQ_HZ-1, counter=CLK_FREQ_HZ-1, synchronizers=0.
REQ-032 Reset asserted mid-count or with interrupt pending SHALL abandon both, with no tick on the first cycle after release.

Structure
REQ-033 Timer register offsets, CTRL/STATUS bit positions and the 24-bit timer width SHALL live in the shared package picoblaze_io_pkg.
REQ-034 The timer and interrupt/overrun logic SHALL be a sub-module, picoblaze_io_timer; decode, registers and the read mux stay in the top level.

Verification
REQ-035 Reset, then idle with CLK_FREQ_HZ=16 -> interrupt rises 16 cycles after reset release and every 16 cycles thereafter while acked.
REQ-036 Write 8'hA5 to port 8'h12 -> out_data[23:16]=8'hA5 next cycle, other registers unchanged; write to 8'h1F -> no out_data change.
REQ-037 in_data[15:8]=8'h3C, port_id=8'h01 -> in_port=8'h3C within 3 cycles; port_id=8'h55 -> in_port=8'h00.
REQ-038 Stage reload 24'h000004, write CTRL=8'h03 -> ticks every 5 cycles; leave interrupt unacked through 2 ticks -> STATUS=8'h07; write CTRL=8'h05 -> STATUS bit2 clears.
REQ-039 Drive ack in the same cycle as tick -> interrupt stays 1; drive commit in the same cycle the counter hits 0 -> no tick, new period takes effect.
REQ-040 Assert reset_n=0 mid-count with interrupt=1 -> all values per REQ-031 after one edge.

Source files
------------

// File: rtl/picoblaze_io_pkg.sv
// Shared definitions for the PicoBlaze I/O bank: data and timer widths, timer
// register offsets, CTRL bit positions and the STATUS layout.
package picoblaze_io_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TMR_W  = 24;

  // Timer register offsets relative to TMR_BASE
  localparam logic [1:0] TMR_OFS_RL0  = 2'd0;
  localparam logic [1:0] TMR_OFS_RL1  = 2'd1;
  localparam logic [1:0] TMR_OFS_RL2  = 2'd2;
  localparam logic [1:0] TMR_OFS_CTRL = 2'd3;

  // CTRL write bits
  localparam int unsigned CTRL_EN_BIT      = 0;
  localparam int unsigned CTRL_COMMIT_BIT  = 1;
  localparam int unsigned CTRL_CLR_OVR_BIT = 2;

  // Timer register write request from the address decoder
  typedef struct packed {
    logic              we;
    logic [1:0]        ofs;
    logic [DATA_W-1:0] data;
  } tmr_wr_t;

  // Timer status flags; field order is the STATUS bit order (ovr=2, irq=1, en=0)
  typedef struct packed {
    logic ovr;
    logic irq;
    logic en;
  } tmr_stat_t;

  function automatic logic [DATA_W-1:0] status_byte(input tmr_stat_t s);
    return {5'b0_0000, s};
  endfunction

endpackage

// File: rtl/picoblaze_io_bank_if.sv
// PicoBlaze port bus. master = processor side, slave = I/O bank side.
//   port_id/out_port/write_strobe/read_strobe : processor -> bank
//   in_port                                   : registered read data
//   interrupt/interrupt_ack                   : level request and acknowledge
interface picoblaze_io_bank_if;
  import picoblaze_io_pkg::*;

  logic [DATA_W-1:0] port_id;
  logic              write_strobe;
  logic [DATA_W-1:0] out_port;
  logic              read_strobe;
  logic [DATA_W-1:0] in_port;
  logic              interrupt;
  logic              interrupt_ack;

  modport master (
    output port_id, write_strobe, out_port, read_strobe, interrupt_ack,
    input  in_port, interrupt
  );

  modport slave (
    input  port_id, write_strobe, out_port, read_strobe, interrupt_ack,
    output in_port, interrupt
  );

endinterface

// File: rtl/picoblaze_io_timer.sv
// Periodic timer with staged/active reload, level interrupt and sticky overrun.
//   clk, reset_n : clock, synchronous active-low reset
//   wr_i         : decoded write to a timer register (offset + data)
//   ack_i        : interrupt acknowledge strobe
//   staged_o     : staged reload value (for read-back)
//   stat_o       : registered enable / interrupt / overrun flags
module picoblaze_io_timer
  import picoblaze_io_pkg::*;
#(
  parameter logic [TMR_W-1:0] RESET_RELOAD = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  tmr_wr_t          wr_i,
  input  logic             ack_i,
  output logic [TMR_W-1:0] staged_o,
  output tmr_stat_t        stat_o
);

  logic [TMR_W-1:0] staged_q, staged_d;
  logic [TMR_W-1:0] active_q, active_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             irq_q, irq_d;
  logic             ovr_q, ovr_d;
  logic             ctrl_wr_c, commit_c, clr_ovr_c, tick_c;

  // State registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      staged_q <= RESET_RELOAD;
      active_q <= RESET_RELOAD;
      cnt_q    <= RESET_RELOAD;
      en_q     <= 1'b1;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      staged_q <= staged_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      en_q     <= en_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

  // Register writes, countdown, tick, interrupt and overrun
  always_comb begin
    staged_d = staged_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    en_d     = en_q;
    irq_d    = irq_q;
    ovr_d    = ovr_q;
    tick_c   = 1'b0;

    ctrl_wr_c = wr_i.we && (wr_i.ofs == TMR_OFS_CTRL);
    commit_c  = ctrl_wr_c && wr_i.data[CTRL_COMMIT_BIT];
    clr_ovr_c = ctrl_wr_c && wr_i.data[CTRL_CLR_OVR_BIT];

    if (wr_i.we) begin
      case (wr_i.ofs)
        TMR_OFS_RL0:  staged_d[7:0]   = wr_i.data;
        TMR_OFS_RL1:  staged_d[15:8]  = wr_i.data;
        TMR_OFS_RL2:  staged_d[23:16] = wr_i.data;
        TMR_OFS_CTRL: en_d            = wr_i.data[CTRL_EN_BIT];
        default:      ;
      endcase
    end

    // A commit overrides the countdown, including the cycle that would tick
    if (commit_c) begin
      active_d = staged_q;
      cnt_d    = staged_q;
    end else if (en_q) begin
      if (cnt_q == '0) begin
        tick_c = 1'b1;
        cnt_d  = active_q;
      end else begin
        cnt_d = cnt_q - TMR_W'(1);
      end
    end

    // Set wins over clear for both flags
    if (clr_ovr_c)                  ovr_d = 1'b0;
    if (tick_c && irq_q && !ack_i)  ovr_d = 1'b1;
    if (ack_i)                      irq_d = 1'b0;
    if (tick_c)                     irq_d = 1'b1;
  end

  assign staged_o   = staged_q;
  assign stat_o.ovr = ovr_q;
  assign stat_o.irq = irq_q;
  assign stat_o.en  = en_q;

endmodule

// File: rtl/picoblaze_io_bank.sv
// PicoBlaze I/O bank: output registers, synchronized input ports, a periodic
// interrupt timer and the registered read mux, all fully address-decoded.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : PicoBlaze port bus (slave side)
//   in_data      : NUM_IN asynchronous 8-bit input ports, port i at [8i+7:8i]
//   out_data     : NUM_OUT 8-bit output registers, register i at [8i+7:8i]
module picoblaze_io_bank
  import picoblaze_io_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 250000,
  parameter int unsigned NUM_OUT     = 4,
  parameter int unsigned NUM_IN      = 2,
  parameter logic [7:0]  OUT_BASE    = 8'h10,
  parameter logic [7:0]  IN_BASE     = 8'h00,
  parameter logic [7:0]  TMR_BASE    = 8'hF0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  picoblaze_io_bank_if.slave    bus,
  input  logic [NUM_IN*8-1:0]   in_data,
  output logic [NUM_OUT*8-1:0]  out_data
);

  localparam logic [TMR_W-1:0] RESET_RELOAD = TMR_W'(CLK_FREQ_HZ - 1);

  logic [NUM_OUT*8-1:0] out_q, out_d;
  logic [NUM_IN*8-1:0]  sync1_q, sync2_q;
  logic [DATA_W-1:0]    in_port_q, in_port_d;
  logic [DATA_W-1:0]    tmr_ofs_c;
  logic                 tmr_hit_c;
  tmr_wr_t              tmr_wr_c;
  logic [TMR_W-1:0]     staged;
  tmr_stat_t            stat;
  logic                 unused_c;

  // Reads are decoded every cycle regardless of the strobe
  assign unused_c = bus.read_strobe;

  // Timer window match; 8-bit wrap keeps the decode exact for any base
  assign tmr_ofs_c = DATA_W'(bus.port_id - TMR_BASE);
  assign tmr_hit_c = (tmr_ofs_c < DATA_W'(4));

  assign tmr_wr_c.we   = bus.write_strobe && tmr_hit_c;
  assign tmr_wr_c.ofs  = tmr_ofs_c[1:0];
  assign tmr_wr_c.data = bus.out_port;

  picoblaze_io_timer #(
    .RESET_RELOAD (RESET_RELOAD)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_i     (tmr_wr_c),
    .ack_i    (bus.interrupt_ack),
    .staged_o (staged),
    .stat_o   (stat)
  );

  // Output register writes
  always_comb begin
    out_d = out_q;
    if (bus.write_strobe) begin
      for (int unsigned i = 0; i < NUM_OUT; i++) begin
        if (bus.port_id == 8'(32'(OUT_BASE) + i)) out_d[i*8 +: 8] = bus.out_port;
      end
    end
  end

  // Read mux: synchronized inputs, output register read-back, timer registers
  always_comb begin
    in_port_d = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (bus.port_id == 8'(32'(IN_BASE) + i)) in_port_d = sync2_q[i*8 +: 8];
    end
    for (int unsigned i = 0; i < NUM_OUT; i++) begin
      if (bus.port_id == 8'(32'(OUT_BASE) + i)) in_port_d = out_q[i*8 +: 8];
    end
    if (tmr_hit_c) begin
      case (tmr_ofs_c[1:0])
        TMR_OFS_RL0:  in_port_d = staged[7:0];
        TMR_OFS_RL1:  in_port_d = staged[15:8];
        TMR_OFS_RL2:  in_port_d = staged[23:16];
        TMR_OFS_CTRL: in_port_d = status_byte(stat);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      in_port_q <= '0;
    end else begin
      out_q     <= out_d;
      sync1_q   <= in_data;
      sync2_q   <= sync1_q;
      in_port_q <= in_port_d;
    end
  end

  assign out_data      = out_q;
  assign bus.in_port   = in_port_q;
  assign bus.interrupt = stat.irq;

endmodule
